// File: rtl/mult_sequencer_pkg.sv
// Shared types and constants for the multiply sequencer.
// Opcode, state encoding and datapath widths.
package cpu_pkg;

  localparam int REG_ADDR_W = 3;
  localparam int DATA_W     = 16;
  localparam int PROD_W     = 2 * DATA_W;
  localparam int CNT_W      = 4;

  localparam logic [5:0] OPC_MULT = 6'b100001;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MUL   = 2'd1,
    WB_LO = 2'd2,
    WB_HI = 2'd3
  } mseq_state_t;

  // True when IR' holds a MULT worth accepting.
  function automatic logic is_mult(
    input logic       vld,
    input logic [5:0] opc
  );
    return vld && (opc == OPC_MULT);
  endfunction

endpackage

// File: rtl/mult_sequencer_if.sv
// Issue, multiplier and writeback signals of the sequencer.
// slave = sequencer side, master = pipeline/environment side.
interface mult_sequencer_if;
  import cpu_pkg::*;

  logic                  issue_valid;
  logic [5:0]            encoded_opcode;
  logic [REG_ADDR_W-1:0] reg_write_addr;
  logic [DATA_W-1:0]     rs1data;
  logic [DATA_W-1:0]     rs2data;
  logic [PROD_W-1:0]     mult_product;

  logic [DATA_W-1:0]     mult_a;
  logic [DATA_W-1:0]     mult_b;
  logic                  mult_enable;
  logic                  stall;
  logic                  busy;
  logic                  wb_en;
  logic [REG_ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0]     wb_data;
  logic                  status_we;
  logic                  status_z;
  logic                  status_n;

  modport slave (
    input  issue_valid,
    input  encoded_opcode,
    input  reg_write_addr,
    input  rs1data,
    input  rs2data,
    input  mult_product,
    output mult_a,
    output mult_b,
    output mult_enable,
    output stall,
    output busy,
    output wb_en,
    output wb_addr,
    output wb_data,
    output status_we,
    output status_z,
    output status_n
  );

  modport master (
    output issue_valid,
    output encoded_opcode,
    output reg_write_addr,
    output rs1data,
    output rs2data,
    output mult_product,
    input  mult_a,
    input  mult_b,
    input  mult_enable,
    input  stall,
    input  busy,
    input  wb_en,
    input  wb_addr,
    input  wb_data,
    input  status_we,
    input  status_z,
    input  status_n
  );

endinterface

// File: rtl/mult_sequencer.sv
// Multi-cycle MULT sequencer: latch, run multiplier,
// then write the product back as two 16-bit halves.
module mult_sequencer
  import cpu_pkg::*;
#(
  parameter int MULT_LATENCY = 3
) (
  input  logic             CLOCK,
  input  logic             RESET_N,
  mult_sequencer_if.slave  bus_io
);

  localparam logic [CNT_W-1:0] CNT_LOAD =
    CNT_W'(MULT_LATENCY - 1);

  mseq_state_t           state_q, state_d;
  logic [DATA_W-1:0]     a_q, a_d;
  logic [DATA_W-1:0]     b_q, b_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [PROD_W-1:0]     prod_q, prod_d;

  // State and datapath registers, synchronous reset.
  always_ff @(posedge CLOCK) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
    end
  end

  // Next state: accept, count down, capture, write back.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    unique case (state_q)
      IDLE: begin
        if (is_mult(bus_io.issue_valid,
                    bus_io.encoded_opcode)) begin
          a_d     = bus_io.rs1data;
          b_d     = bus_io.rs2data;
          rd_d    = bus_io.reg_write_addr;
          cnt_d   = CNT_LOAD;
          state_d = MUL;
        end
      end
      MUL: begin
        if (cnt_q == '0) begin
          prod_d  = bus_io.mult_product;
          state_d = WB_LO;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      WB_LO:   state_d = WB_HI;
      WB_HI:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state; strobed fields zero when idle.
  always_comb begin
    bus_io.mult_a      = a_q;
    bus_io.mult_b      = b_q;
    bus_io.mult_enable = 1'b0;
    bus_io.busy        = (state_q != IDLE);
    bus_io.stall       = (state_q != IDLE);
    bus_io.wb_en       = 1'b0;
    bus_io.wb_addr     = '0;
    bus_io.wb_data     = '0;
    bus_io.status_we   = 1'b0;
    bus_io.status_z    = 1'b0;
    bus_io.status_n    = 1'b0;
    unique case (1'b1)
      (state_q == MUL): begin
        bus_io.mult_enable = 1'b1;
      end
      (state_q == WB_LO): begin
        bus_io.wb_en   = 1'b1;
        bus_io.wb_addr = rd_q;
        bus_io.wb_data = prod_q[DATA_W-1:0];
      end
      (state_q == WB_HI): begin
        bus_io.wb_en     = 1'b1;
        bus_io.wb_addr   = rd_q + 3'd1;
        bus_io.wb_data   = prod_q[PROD_W-1:DATA_W];
        bus_io.status_we = 1'b1;
        bus_io.status_z  = (prod_q == '0);
        bus_io.status_n  = prod_q[PROD_W-1];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mult_sequencer.sv
// Directed vector bench for mult_sequencer.
// Cycle-exact checks of stall, enable and writeback.
module tb_mult_sequencer;
  import cpu_pkg::*;

  localparam int LAT = 3;
  localparam logic [5:0] OPC_ADD = 6'b000010;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  rd;
    logic [15:0] lo;
    logic [15:0] hi;
    logic        z;
    logic        n;
  } vec_t;

  logic CLOCK   = 1'b0;
  logic RESET_N = 1'b0;
  int   total   = 0;
  int   bad     = 0;
  vec_t vecs[4];
  vec_t nullv;

  mult_sequencer_if bus();

  mult_sequencer #(.MULT_LATENCY(LAT)) dut (
    .CLOCK  (CLOCK),
    .RESET_N(RESET_N),
    .bus_io (bus)
  );

  always #5 CLOCK = ~CLOCK;

  assign bus.mult_product = bus.mult_enable
    ? 32'(bus.mult_a) * 32'(bus.mult_b) : 32'h0;

  task automatic chk(
    input string       tag,
    input string       what,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s.%s got=%h want=%h",
               tag, what, got, exp);
    end
  endtask

  task automatic chk_outs(
    input string       tag,
    input logic        st,
    input logic        me,
    input logic        we,
    input logic [2:0]  wa,
    input logic [15:0] wd,
    input logic        swe,
    input logic        z,
    input logic        n
  );
    chk(tag, "stall", 32'(bus.stall), 32'(st));
    chk(tag, "busy", 32'(bus.busy), 32'(st));
    chk(tag, "men", 32'(bus.mult_enable), 32'(me));
    chk(tag, "wb_en", 32'(bus.wb_en), 32'(we));
    chk(tag, "wb_addr", 32'(bus.wb_addr), 32'(wa));
    chk(tag, "wb_data", 32'(bus.wb_data), 32'(wd));
    chk(tag, "st_we", 32'(bus.status_we), 32'(swe));
    chk(tag, "st_z", 32'(bus.status_z), 32'(z));
    chk(tag, "st_n", 32'(bus.status_n), 32'(n));
  endtask

  task automatic drive(
    input logic       vld,
    input logic [5:0] opc,
    input vec_t       v
  );
    bus.issue_valid    = vld;
    bus.encoded_opcode = opc;
    bus.rs1data        = v.a;
    bus.rs2data        = v.b;
    bus.reg_write_addr = v.rd;
  endtask

  // Entered at the negedge of accept cycle T, returns at T+6.
  task automatic run_mult(
    input string      tag,
    input vec_t       v,
    input logic       hv,
    input logic [5:0] hop,
    input vec_t       h
  );
    logic [2:0] hi_addr;
    hi_addr = v.rd + 3'd1;
    chk_outs(tag, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1'b1, OPC_MULT, v);
    for (int k = 1; k <= LAT; k++) begin
      @(negedge CLOCK);
      if (k == 1) drive(hv, hop, h);
      chk_outs(tag, 1, 1, 0, 0, 0, 0, 0, 0);
      chk(tag, "mult_a", 32'(bus.mult_a), 32'(v.a));
      chk(tag, "mult_b", 32'(bus.mult_b), 32'(v.b));
    end
    @(negedge CLOCK);
    chk_outs(tag, 1, 0, 1, v.rd, v.lo, 0, 0, 0);
    @(negedge CLOCK);
    chk_outs(tag, 1, 0, 1, hi_addr, v.hi,
             1, v.z, v.n);
    @(negedge CLOCK);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{16'h1234, 16'h0010, 3'd2,
                16'h2340, 16'h0001, 1'b0, 1'b0};
    vecs[1] = '{16'h0000, 16'hFFFF, 3'd4,
                16'h0000, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'hFFFF, 16'hFFFF, 3'd5,
                16'h0001, 16'hFFFE, 1'b0, 1'b1};
    vecs[3] = '{16'h0100, 16'h0300, 3'd7,
                16'h0000, 16'h0003, 1'b0, 1'b0};
    nullv   = '{16'hAAAA, 16'h5555, 3'd6,
                16'h0, 16'h0, 1'b0, 1'b0};

    drive(1'b0, 6'd0, nullv);
    RESET_N = 1'b0;
    repeat (3) @(negedge CLOCK);
    RESET_N = 1'b1;
    chk_outs("rst", 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst", "mult_a", 32'(bus.mult_a), 32'h0);
    chk("rst", "mult_b", 32'(bus.mult_b), 32'h0);

    drive(1'b1, 6'b010001, nullv);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLOCK);
      chk_outs("nonmul", 0, 0, 0, 0, 0, 0, 0, 0);
      chk("nonmul", "mult_a", 32'(bus.mult_a), 32'h0);
    end

    for (int i = 0; i < 4; i++) begin
      if (i < 3)
        run_mult($sformatf("v%0d", i), vecs[i],
                 1'b1, OPC_MULT, vecs[i+1]);
      else
        run_mult($sformatf("v%0d", i), vecs[i],
                 1'b1, OPC_ADD, nullv);
    end

    chk_outs("addT6", 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge CLOCK);
    chk_outs("addT7", 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1'b0, 6'd0, nullv);
    @(negedge CLOCK);

    drive(1'b1, OPC_MULT, vecs[2]);
    @(negedge CLOCK);
    drive(1'b0, 6'd0, nullv);
    chk_outs("abT1", 1, 1, 0, 0, 0, 0, 0, 0);
    @(negedge CLOCK);
    chk_outs("abT2", 1, 1, 0, 0, 0, 0, 0, 0);
    RESET_N = 1'b0;
    @(negedge CLOCK);
    RESET_N = 1'b1;
    chk_outs("abT3", 0, 0, 0, 0, 0, 0, 0, 0);
    chk("abT3", "mult_a", 32'(bus.mult_a), 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge CLOCK);
      chk_outs("abpost", 0, 0, 0, 0, 0, 0, 0, 0);
    end

    run_mult("again", vecs[0], 1'b0, 6'd0, nullv);
    chk_outs("end", 0, 0, 0, 0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mult_sequencer.md
# mult_sequencer

Multi-cycle sequencer for the CPU's clocked 16x16 multiplier. It accepts a MULT (encoded opcode 6'b100001) from the decode stage and latches its operands. It then drives the multiplier enable for a fixed latency while stalling the pipeline, and writes the 32-bit product back to the register file over two cycles (low half to Rd, high half to Rd+1). It sits beside the ALU, between the IR' decode outputs, the multiplier and the register-file write port.

## Interface
- MULT_LATENCY, 3: cycles mult_enable is held before the product is sampled; legal range 1..15.
- CLOCK  in  1  system clock; all state on rising edge.
- RESET_N  in  1  synchronous, active-low reset.
- issue_valid  in  1  IR' holds a valid decoded instruction this cycle.
- encoded_opcode  in  6  decoded opcode from IR'.
- reg_write_addr  in  3  destination register Rd.
- rs1data  in  16  operand A from register file.
- rs2data  in  16  operand B from register file.
- mult_product  in  32  multiplier output P.
- mult_a  out  16  latched operand A to multiplier.
- mult_b  out  16  latched operand B to multiplier.
- mult_enable  out  1  multiplier enable.
- stall  out  1  hold fetch/decode; IR' must not advance.
- busy  out  1  state is not IDLE.
- wb_en  out  1  register-file write strobe.
- wb_addr  out  3  write address.
- wb_data  out  16  write data.
- status_we  out  1  update the Z and N flags.
- status_z  out  1  product == 0.
- status_n  out  1  product[31].

## Operation
- States: IDLE, MUL, WB_LO, WB_HI. Encoding lives in the package.
- IDLE:
  - On issue_valid && encoded_opcode == OPC_MULT, latch rs1data→a_reg, rs2data→b_reg and reg_write_addr→rd_reg, load cnt = MULT_LATENCY-1, and go to MUL.
  - Any other opcode is ignored and all outputs stay 0.
  - The MULT itself is consumed in the accept cycle, and stall is low that cycle.
- MUL:
  - mult_enable = 1 and mult_a/mult_b = a_reg/b_reg (these are held in all states).
  - If cnt == 0, capture mult_product into prod_reg and go to WB_LO. Otherwise cnt decrements.
- WB_LO: wb_en = 1, wb_addr = rd_reg, wb_data = prod_reg[15:0], then go to WB_HI.
- WB_HI:
  - wb_en = 1, wb_addr = rd_reg + 1 modulo 8 (Rd = 7 writes R0), wb_data = prod_reg[31:16].
  - status_we = 1, status_z = (prod_reg == 0) over all 32 bits, status_n = prod_reg[31].
  - Go to IDLE.
- stall = busy = (state != IDLE). Issue inputs are not sampled while busy; the instruction held in IR' is evaluated on the first IDLE cycle.
- wb_data, wb_addr, status_z and status_n are 0 whenever their strobe is low.
- Products are unsigned 32-bit; no truncation; carry and overflow flags are untouched.

## Timing
- Reset (RESET_N low at an edge):
  - State goes to IDLE; a_reg, b_reg, prod_reg, rd_reg and cnt clear to 0.
  - Every output is 0 from the following cycle.
  - Reset mid-operation aborts with no writeback.
- Accept at cycle T:
  - MUL occupies T+1..T+MULT_LATENCY.
  - Product is sampled at the edge ending cycle T+MULT_LATENCY.
  - WB_LO is T+MULT_LATENCY+1; WB_HI is T+MULT_LATENCY+2.
  - IDLE resumes at T+MULT_LATENCY+3.
- stall is high for exactly MULT_LATENCY+2 cycles.
- Back-to-back MULTs: the second is accepted on the first IDLE cycle, with no bubble beyond that.
- MULT_LATENCY = 1 gives one MUL cycle.

## Structure
- Package cpu_pkg holds:
  - OPC_MULT = 6'b100001;
  - the mseq_state_t enum (IDLE, MUL, WB_LO, WB_HI);
  - REG_ADDR_W = 3, DATA_W = 16.
- Single module with no sub-modules.
- cnt width is 4 bits, covering MULT_LATENCY up to 15.

## Test plan
- Basic multiply (MULT_LATENCY = 3):
  - Stimulus: MULT with rs1 = 16'h1234, rs2 = 16'h0010, Rd = 2, and a model returning P = A*B once enabled.
  - Required: wb R2 = 16'h2340 at T+4 and R3 = 16'h0001 at T+5; status_we with Z = 0, N = 0; stall high T+1..T+5.
- Zero and negative flags:
  - 0 * 16'hFFFF requires Z = 1, N = 0.
  - 16'hFFFF * 16'hFFFF requires lo 16'h0001, hi 16'hFFFE, N = 1.
- Address wrap: Rd = 7 requires the low half to R7 and the high half to R0.
- Held instruction under stall:
  - Stimulus: ADD placed on issue during busy.
  - Required: no second accept; the ADD is seen only at T+6.
  - Back-to-back MULTs are accepted at T and T+6.
- Reset mid-op:
  - Stimulus: RESET_N low during the MUL cycle T+2.
  - Required: next cycle is IDLE, stall = 0, and no wb_en pulse follows.
- Non-MULT opcodes (e.g., 6'b010001) in IDLE: all outputs stay 0 and busy stays 0.
